// File: rtl/md_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_iter
// Brief    : Iterative multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit_iter #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int c_cnt_max = (MULT_CYCLES > WIDTH) ? MULT_CYCLES - 1 : WIDTH - 1;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_w2      = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [c_w2-1:0]      prod_q, prod_d;
    logic [1:0]           acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 w_accept;
    logic                 w_msgn;
    logic [c_w2-1:0]      w_ea, w_eb, w_prod, w_hilo, w_mres;
    logic                 w_na, w_nb;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b;
    logic [WIDTH:0]       w_rem_sh, w_trial;
    logic [WIDTH-1:0]     w_q_fix, w_r_fix;

    assign w_accept = (state_q == S_IDLE) && start_i && !cancel_i && (op_i <= 4'd9);

    // Operands are extended to the full product width so one multiplier serves both signednesses.
    assign w_msgn = (op_i == 4'd0) || (op_i == 4'd4) || (op_i == 4'd6);
    assign w_ea   = w_msgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign w_eb   = w_msgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign w_prod = w_ea * w_eb;

    assign w_hilo = {hi_q, lo_q};
    always_comb begin
        w_mres = prod_q;
        case (acc_q)
            2'd1:    w_mres = w_hilo + prod_q;
            2'd2:    w_mres = w_hilo - prod_q;
            default: w_mres = prod_q;
        endcase
    end

    assign w_na    = (op_i == 4'd2) && a_i[WIDTH-1];
    assign w_nb    = (op_i == 4'd2) && b_i[WIDTH-1];
    assign w_abs_a = w_na ? -a_i : a_i;
    assign w_abs_b = w_nb ? -b_i : b_i;

    // Restoring step: the dividend shifts out of quo_q while quotient bits shift in.
    assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, dvs_q};

    assign w_q_fix = negq_q ? -quo_q : quo_q;
    assign w_r_fix = negr_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_i)
                        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                            state_d = S_MUL;
                            cnt_d   = c_cnt_w'(MULT_CYCLES - 1);
                            prod_d  = w_prod;
                            acc_d   = (op_i == 4'd4 || op_i == 4'd5) ? 2'd1 :
                                      (op_i == 4'd6 || op_i == 4'd7) ? 2'd2 : 2'd0;
                        end
                        4'd2, 4'd3: begin
                            state_d = S_DIV;
                            cnt_d   = c_cnt_w'(WIDTH - 1);
                            rem_d   = '0;
                            quo_d   = w_abs_a;
                            dvs_d   = w_abs_b;
                            negq_d  = w_na ^ w_nb;
                            negr_d  = w_na;
                            dz_d    = (b_i == '0);
                        end
                        4'd8:    hi_d = a_i;
                        4'd9:    lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = w_mres;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!w_trial[WIDTH]) begin
                        rem_d = w_trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = w_rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    // With a zero divisor the remainder already equals the dividend; only LO is forced.
                    lo_d    = dz_q ? '1 : w_q_fix;
                    hi_d    = w_r_fix;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit_iter
// Brief    : Randomised and directed checks of md_unit_iter against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit_iter;

    localparam int WIDTH       = 32;
    localparam int MULT_CYCLES = 5;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        cancel_i = 1'b0;
    logic        busy_o;
    logic [31:0] hi_o, lo_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] hl_m = '0;

    md_unit_iter #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES)) u_dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cancel_i(cancel_i),
        .busy_o  (busy_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] sp = sa * sb;
        longint      q, r;
        case (op)
            4'd0: return sp;
            4'd1: return ua * ub;
            4'd4: return hl + sp;
            4'd5: return hl + ua * ub;
            4'd6: return hl - sp;
            4'd7: return hl - ua * ub;
            4'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd8:    return {a, hl[31:0]};
            4'd9:    return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic int exp_cycles(input logic [3:0] op);
        if (op == 4'd2 || op == 4'd3) return WIDTH + 1;
        if (op <= 4'd7) return MULT_CYCLES;
        return 0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // cancel_at / inject_at: busy-cycle index at which to raise cancel or a stray start (-1 = never)
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int inject_at);
        int n = 0;
        bit killed = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (busy_o && n < 200) begin
            n++;
            if (n == cancel_at) cancel_i = 1'b1;
            if (n == inject_at) begin
                start_i = 1'b1; op_i = 4'd9; a_i = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start_i  = 1'b0;
            cancel_i = 1'b0;
            if (n == cancel_at) begin
                killed = 1;
                break;
            end
        end
        if (killed) begin
            chk($sformatf("busy after cancel op%0d", op), {63'd0, busy_o}, 64'd0);
        end else begin
            hl_m = model(op, a, b, hl_m);
            chk($sformatf("busy cycles op%0d", op), 64'(n), 64'(exp_cycles(op)));
        end
        chk($sformatf("hilo op%0d a=%h b=%h", op, a, b), {hi_o, lo_o}, hl_m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rop;
        int         n;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        chk("reset busy", {63'd0, busy_o}, 64'd0);
        chk("reset hilo", {hi_o, lo_o}, 64'd0);

        run_op(4'd0, 32'hFFFF_FFFD, 32'd7, -1, -1);
        chk("mult -3*7 literal", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(4'd3, 32'd100, 32'd7, -1, -1);
        chk("divu 100/7 literal", {hi_o, lo_o}, {32'd2, 32'd14});
        run_op(4'd2, 32'hFFFF_FF9C, 32'd7, -1, -1);
        chk("div -100/7 literal", {hi_o, lo_o}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(4'd2, 32'h1234_5678, 32'd0, -1, -1);
        run_op(4'd2, 32'hF234_5678, 32'd0, -1, -1);
        run_op(4'd0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(4'd8, 32'd1, 32'd0, -1, -1);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd0, -1, -1);
        run_op(4'd5, 32'd1, 32'd1, -1, -1);
        chk("maddu carry literal", {hi_o, lo_o}, {32'd2, 32'd0});
        run_op(4'd8, 32'd0, 32'd0, -1, -1);
        run_op(4'd9, 32'd0, 32'd0, -1, -1);
        run_op(4'd6, 32'd1, 32'd1, -1, -1);
        chk("msub borrow literal", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(4'd2, 32'd12345, 32'd17, 10, -1);
        run_op(4'd0, 32'd9, 32'd9, MULT_CYCLES, -1);
        run_op(4'd3, 32'd99, 32'd4, WIDTH + 1, -1);
        run_op(4'd0, 32'd3, 32'd4, -1, 2);

        // start together with cancel must be dropped entirely
        @(negedge clk);
        start_i = 1'b1; cancel_i = 1'b1; op_i = 4'd8; a_i = 32'h5555_AAAA;
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        chk("start+cancel mthi", {hi_o, lo_o}, hl_m);
        @(negedge clk);
        start_i = 1'b1; cancel_i = 1'b1; op_i = 4'd2; a_i = 32'd50; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        chk("start+cancel div busy", {63'd0, busy_o}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = (($urandom_range(0, 9)) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_op(rop, pick(), pick(), -1, -1);
        end

        // reset in the middle of a divide
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd3; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 0;
        while (n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy before mid-div reset", {63'd0, busy_o}, 64'd1);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        hl_m = '0;
        chk("busy after mid-div reset", {63'd0, busy_o}, 64'd0);
        chk("hilo after mid-div reset", {hi_o, lo_o}, hl_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
